// File: rtl/fetch_redirect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_ctrl_if
// Brief    : Redirect request / IF-backend flush bundle for fetch_redirect_ctrl.
//            master = redirect producer and flush consumer side,
//            slave  = the redirect controller itself.
//            Statistics signals exist only when FETCH_REDIRECT_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_redirect_ctrl_if #(
    parameter int INST_ADDR_WIDTH = 32,
    parameter int ROB_IDX_BITS    = 5
);
    // Request side
    logic                       ext_stall;
    logic [ROB_IDX_BITS-1:0]    rob_head;
    logic                       commit_redir_valid;
    logic [INST_ADDR_WIDTH-1:0] commit_redir_pc;
    logic                       ex0_mispred_valid;
    logic [INST_ADDR_WIDTH-1:0] ex0_mispred_pc;
    logic [ROB_IDX_BITS-1:0]    ex0_rob_idx;
    logic                       ex1_mispred_valid;
    logic [INST_ADDR_WIDTH-1:0] ex1_mispred_pc;
    logic [ROB_IDX_BITS-1:0]    ex1_rob_idx;

    // IF / backend side
    logic                       if_flush;
    logic                       if_redirect_valid;
    logic [INST_ADDR_WIDTH-1:0] if_redirect_pc;
    logic                       if_stall;
    logic                       be_flush_valid;
    logic                       be_flush_all;
    logic [ROB_IDX_BITS-1:0]    be_flush_rob_idx;

`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0]                stat_commit_cnt;
    logic [31:0]                stat_ex_cnt;
    logic [31:0]                stat_drop_cnt;
`endif

    modport master (
`ifdef FETCH_REDIRECT_STATS_EN
        input  stat_commit_cnt,
        input  stat_ex_cnt,
        input  stat_drop_cnt,
`endif
        output ext_stall,
        output rob_head,
        output commit_redir_valid,
        output commit_redir_pc,
        output ex0_mispred_valid,
        output ex0_mispred_pc,
        output ex0_rob_idx,
        output ex1_mispred_valid,
        output ex1_mispred_pc,
        output ex1_rob_idx,
        input  if_flush,
        input  if_redirect_valid,
        input  if_redirect_pc,
        input  if_stall,
        input  be_flush_valid,
        input  be_flush_all,
        input  be_flush_rob_idx
    );

    modport slave (
`ifdef FETCH_REDIRECT_STATS_EN
        output stat_commit_cnt,
        output stat_ex_cnt,
        output stat_drop_cnt,
`endif
        input  ext_stall,
        input  rob_head,
        input  commit_redir_valid,
        input  commit_redir_pc,
        input  ex0_mispred_valid,
        input  ex0_mispred_pc,
        input  ex0_rob_idx,
        input  ex1_mispred_valid,
        input  ex1_mispred_pc,
        input  ex1_rob_idx,
        output if_flush,
        output if_redirect_valid,
        output if_redirect_pc,
        output if_stall,
        output be_flush_valid,
        output be_flush_all,
        output be_flush_rob_idx
    );
endinterface
`default_nettype wire

// File: rtl/fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_redirect_ctrl
// Brief    : Arbitrates commit trap and two execute mispredict redirects,
//            issues a one-cycle flush/redirect pulse for the oldest request and
//            then stalls IF for RECOVER_CYCLES cycles.
//            Optional macro FETCH_REDIRECT_STATS_EN adds saturating
//            accepted/dropped request counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_redirect_ctrl #(
    parameter int INST_ADDR_WIDTH = 32,
    parameter int ROB_IDX_BITS    = 5,
    parameter int RECOVER_CYCLES  = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    fetch_redirect_ctrl_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_RECOVER = 2'd2;
    localparam logic [3:0] c_RECOVER_LOAD = 4'(RECOVER_CYCLES);

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic [3:0]                 r_cnt;
    logic [ROB_IDX_BITS-1:0]    r_held_idx;
    logic                       r_held_all;
    logic                       r_pulse;
    logic                       r_flush_all;
    logic [INST_ADDR_WIDTH-1:0] r_pc;
    logic [ROB_IDX_BITS-1:0]    r_idx;

    logic [ROB_IDX_BITS-1:0]    w_age_ex0;
    logic [ROB_IDX_BITS-1:0]    w_age_ex1;
    logic [ROB_IDX_BITS-1:0]    w_age_held;
    logic                       w_ex0_wins;
    logic                       w_ex_valid;
    logic [ROB_IDX_BITS-1:0]    w_ex_age;
    logic [ROB_IDX_BITS-1:0]    w_ex_idx;
    logic [INST_ADDR_WIDTH-1:0] w_ex_pc;
    logic                       w_ex_ok;
    logic                       w_take_commit;
    logic                       w_take_ex;
    logic                       w_accept;

    logic [INST_ADDR_WIDTH-1:0] w_pc_nxt;
    logic [ROB_IDX_BITS-1:0]    w_idx_nxt;
    logic [ROB_IDX_BITS-1:0]    w_held_idx_nxt;
    logic                       w_held_all_nxt;
    logic [3:0]                 w_cnt_nxt;
    logic                       w_if_stall;

    // Ages relative to the current head; modulo wrap falls out of the width.
    assign w_age_ex0  = bus.ex0_rob_idx - bus.rob_head;
    assign w_age_ex1  = bus.ex1_rob_idx - bus.rob_head;
    assign w_age_held = r_held_idx     - bus.rob_head;

    // ex0 wins ties; the losing port is necessarily younger and already dead.
    assign w_ex0_wins = bus.ex0_mispred_valid &&
                        (!bus.ex1_mispred_valid || (w_age_ex0 <= w_age_ex1));
    assign w_ex_valid = bus.ex0_mispred_valid || bus.ex1_mispred_valid;
    assign w_ex_age   = w_ex0_wins ? w_age_ex0 : w_age_ex1;
    assign w_ex_idx   = w_ex0_wins ? bus.ex0_rob_idx : bus.ex1_rob_idx;
    assign w_ex_pc    = w_ex0_wins ? bus.ex0_mispred_pc : bus.ex1_mispred_pc;

    // While a redirect is in flight only a strictly older branch may preempt it,
    // and nothing from execute may preempt a full-window (commit) flush.
    assign w_ex_ok       = (r_state == c_ST_IDLE) ||
                           (!r_held_all && (w_ex_age < w_age_held));
    assign w_take_commit = bus.commit_redir_valid;
    assign w_take_ex     = !bus.commit_redir_valid && w_ex_valid && w_ex_ok;
    assign w_accept      = w_take_commit || w_take_ex;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: any accepted request restarts at ISSUE.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            w_state_nxt = c_ST_ISSUE;
        end else begin
            case (r_state)
                c_ST_IDLE:    w_state_nxt = c_ST_IDLE;
                c_ST_ISSUE:   w_state_nxt = (c_RECOVER_LOAD == 4'd0) ? c_ST_IDLE : c_ST_RECOVER;
                c_ST_RECOVER: w_state_nxt = (r_cnt <= 4'd1) ? c_ST_IDLE : c_ST_RECOVER;
                default:      w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Output/datapath logic: next values of the pulse payload, held context and counter.
    always_comb begin
        w_pc_nxt       = r_pc;
        w_idx_nxt      = r_idx;
        w_held_idx_nxt = r_held_idx;
        w_held_all_nxt = r_held_all;
        w_cnt_nxt      = r_cnt;
        w_if_stall     = bus.ext_stall || (r_state == c_ST_RECOVER);
        if (w_take_commit) begin
            w_pc_nxt       = bus.commit_redir_pc;
            w_idx_nxt      = bus.rob_head;
            w_held_idx_nxt = bus.rob_head;
            w_held_all_nxt = 1'b1;
            w_cnt_nxt      = c_RECOVER_LOAD;
        end else if (w_take_ex) begin
            w_pc_nxt       = w_ex_pc;
            w_idx_nxt      = w_ex_idx;
            w_held_idx_nxt = w_ex_idx;
            w_held_all_nxt = 1'b0;
            w_cnt_nxt      = c_RECOVER_LOAD;
        end else if (w_state_nxt == c_ST_IDLE) begin
            w_held_all_nxt = 1'b0;
            w_cnt_nxt      = 4'd0;
        end else if (r_state == c_ST_RECOVER) begin
            w_cnt_nxt      = r_cnt - 4'd1;
        end
    end

    // Registered pulse, payload, held context and recovery counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 4'd0;
            r_held_idx  <= '0;
            r_held_all  <= 1'b0;
            r_pulse     <= 1'b0;
            r_flush_all <= 1'b0;
            r_pc        <= '0;
            r_idx       <= '0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_held_idx  <= w_held_idx_nxt;
            r_held_all  <= w_held_all_nxt;
            r_pulse     <= w_accept;
            r_flush_all <= w_take_commit;
            r_pc        <= w_pc_nxt;
            r_idx       <= w_idx_nxt;
        end
    end

    assign bus.if_flush          = r_pulse;
    assign bus.if_redirect_valid = r_pulse;
    assign bus.be_flush_valid    = r_pulse;
    assign bus.be_flush_all      = r_flush_all;
    assign bus.if_redirect_pc    = r_pc;
    assign bus.be_flush_rob_idx  = r_idx;
    assign bus.if_stall          = w_if_stall;

`ifdef FETCH_REDIRECT_STATS_EN
    logic [31:0] r_stat_commit;
    logic [31:0] r_stat_ex;
    logic [31:0] r_stat_drop;
    logic [1:0]  w_ex_req_cnt;
    logic [1:0]  w_drop_inc;
    logic [32:0] w_drop_sum;

    // Every execute request that is not the accepted winner counts as dropped.
    assign w_ex_req_cnt = {1'b0, bus.ex0_mispred_valid} + {1'b0, bus.ex1_mispred_valid};
    assign w_drop_inc   = w_ex_req_cnt - {1'b0, w_take_ex};
    assign w_drop_sum   = {1'b0, r_stat_drop} + {31'd0, w_drop_inc};

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_commit <= 32'd0;
            r_stat_ex     <= 32'd0;
            r_stat_drop   <= 32'd0;
        end else begin
            if (w_take_commit && (r_stat_commit != 32'hFFFF_FFFF)) begin
                r_stat_commit <= r_stat_commit + 32'd1;
            end
            if (w_take_ex && (r_stat_ex != 32'hFFFF_FFFF)) begin
                r_stat_ex <= r_stat_ex + 32'd1;
            end
            r_stat_drop <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
        end
    end

    assign bus.stat_commit_cnt = r_stat_commit;
    assign bus.stat_ex_cnt     = r_stat_ex;
    assign bus.stat_drop_cnt   = r_stat_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_redirect_ctrl
// Brief    : Directed self-checking bench for fetch_redirect_ctrl
//            (RECOVER_CYCLES=2 instance plus a RECOVER_CYCLES=0 instance).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_redirect_ctrl;

    localparam int c_AW = 32;
    localparam int c_RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fetch_redirect_ctrl_if #(.INST_ADDR_WIDTH(c_AW), .ROB_IDX_BITS(c_RW)) u_if0 ();
    fetch_redirect_ctrl_if #(.INST_ADDR_WIDTH(c_AW), .ROB_IDX_BITS(c_RW)) u_if1 ();

    fetch_redirect_ctrl #(.INST_ADDR_WIDTH(c_AW), .ROB_IDX_BITS(c_RW), .RECOVER_CYCLES(2))
        u_dut (.clk(clk), .rst(rst), .bus(u_if0.slave));

    fetch_redirect_ctrl #(.INST_ADDR_WIDTH(c_AW), .ROB_IDX_BITS(c_RW), .RECOVER_CYCLES(0))
        u_dut_r0 (.clk(clk), .rst(rst), .bus(u_if1.slave));

    always #5 clk = ~clk;

    // {if_flush, if_redirect_valid, be_flush_valid, be_flush_all}
    wire logic [3:0] w_p0 = {u_if0.if_flush, u_if0.if_redirect_valid, u_if0.be_flush_valid, u_if0.be_flush_all};
    wire logic [3:0] w_p1 = {u_if1.if_flush, u_if1.if_redirect_valid, u_if1.be_flush_valid, u_if1.be_flush_all};

    task automatic clear_inputs();
        u_if0.ext_stall = 0; u_if0.commit_redir_valid = 0; u_if0.commit_redir_pc = '0;
        u_if0.ex0_mispred_valid = 0; u_if0.ex0_mispred_pc = '0; u_if0.ex0_rob_idx = '0;
        u_if0.ex1_mispred_valid = 0; u_if0.ex1_mispred_pc = '0; u_if0.ex1_rob_idx = '0;
        u_if1.ext_stall = 0; u_if1.commit_redir_valid = 0; u_if1.commit_redir_pc = '0;
        u_if1.ex0_mispred_valid = 0; u_if1.ex0_mispred_pc = '0; u_if1.ex0_rob_idx = '0;
        u_if1.ex1_mispred_valid = 0; u_if1.ex1_mispred_pc = '0; u_if1.ex1_rob_idx = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        clear_inputs();
        u_if0.rob_head = 0; u_if1.rob_head = 0;
        rst = 1; step(); step(); rst = 0;
        total++; if (w_p0 !== 4'b0000) begin bad++; $display("FAIL reset_pulses got=%b exp=0000", w_p0); end
        total++; if (u_if0.if_redirect_pc !== 32'h0 || u_if0.be_flush_rob_idx !== 5'd0) begin bad++;
            $display("FAIL reset_payload got pc=%h idx=%0d exp pc=0 idx=0", u_if0.if_redirect_pc, u_if0.be_flush_rob_idx); end
        total++; if (u_if0.if_stall !== 1'b0 || u_if1.if_stall !== 1'b0) begin bad++;
            $display("FAIL reset_stall got=%b/%b exp=0/0", u_if0.if_stall, u_if1.if_stall); end
    endtask

    task automatic test_basic_mispredict();
        u_if0.rob_head = 0;
        u_if0.ex0_mispred_valid = 1; u_if0.ex0_rob_idx = 3; u_if0.ex0_mispred_pc = 32'h100;
        step(); clear_inputs();
        total++; if (w_p0 !== 4'b1110 || u_if0.if_redirect_pc !== 32'h100 || u_if0.be_flush_rob_idx !== 5'd3) begin bad++;
            $display("FAIL basic_pulse got p=%b pc=%h idx=%0d exp p=1110 pc=100 idx=3", w_p0, u_if0.if_redirect_pc, u_if0.be_flush_rob_idx); end
        total++; if (u_if0.if_stall !== 1'b0) begin bad++; $display("FAIL basic_issue_stall got=%b exp=0", u_if0.if_stall); end
        step();
        total++; if (u_if0.if_stall !== 1'b1 || w_p0 !== 4'b0000 || u_if0.if_redirect_pc !== 32'h100) begin bad++;
            $display("FAIL basic_rec1 got stall=%b p=%b pc=%h exp stall=1 p=0000 pc=100", u_if0.if_stall, w_p0, u_if0.if_redirect_pc); end
        step();
        total++; if (u_if0.if_stall !== 1'b1 || w_p0 !== 4'b0000) begin bad++;
            $display("FAIL basic_rec2 got stall=%b p=%b exp stall=1 p=0000", u_if0.if_stall, w_p0); end
        step();
        total++; if (u_if0.if_stall !== 1'b0 || w_p0 !== 4'b0000) begin bad++;
            $display("FAIL basic_idle got stall=%b p=%b exp stall=0 p=0000", u_if0.if_stall, w_p0); end
    endtask

    task automatic test_dual_port_wrap();
        u_if0.rob_head = 30;
        u_if0.ex0_mispred_valid = 1; u_if0.ex0_rob_idx = 1;  u_if0.ex0_mispred_pc = 32'h111;
        u_if0.ex1_mispred_valid = 1; u_if0.ex1_rob_idx = 31; u_if0.ex1_mispred_pc = 32'h131;
        step(); clear_inputs();
        total++; if (w_p0 !== 4'b1110 || u_if0.if_redirect_pc !== 32'h131 || u_if0.be_flush_rob_idx !== 5'd31) begin bad++;
            $display("FAIL dual_wrap got p=%b pc=%h idx=%0d exp p=1110 pc=131 idx=31", w_p0, u_if0.if_redirect_pc, u_if0.be_flush_rob_idx); end
        idle(4);
    endtask

    task automatic test_equal_age();
        u_if0.rob_head = 30;
        u_if0.ex0_mispred_valid = 1; u_if0.ex0_rob_idx = 4; u_if0.ex0_mispred_pc = 32'h44;
        u_if0.ex1_mispred_valid = 1; u_if0.ex1_rob_idx = 4; u_if0.ex1_mispred_pc = 32'h55;
        step(); clear_inputs();
        total++; if (w_p0 !== 4'b1110 || u_if0.if_redirect_pc !== 32'h44) begin bad++;
            $display("FAIL equal_age got p=%b pc=%h exp p=1110 pc=44", w_p0, u_if0.if_redirect_pc); end
        idle(4);
    endtask

    task automatic test_late_older();
        u_if0.rob_head = 0;
        u_if0.ex1_mispred_valid = 1; u_if0.ex1_rob_idx = 10; u_if0.ex1_mispred_pc = 32'hA00;
        step(); clear_inputs();
        step();
        // First RECOVER cycle: older branch preempts.
        u_if0.ex1_mispred_valid = 1; u_if0.ex1_rob_idx = 6; u_if0.ex1_mispred_pc = 32'h600;
        step(); clear_inputs();
        total++; if (w_p0 !== 4'b1110 || u_if0.if_redirect_pc !== 32'h600 || u_if0.be_flush_rob_idx !== 5'd6) begin bad++;
            $display("FAIL late_older_pulse got p=%b pc=%h idx=%0d exp p=1110 pc=600 idx=6", w_p0, u_if0.if_redirect_pc, u_if0.be_flush_rob_idx); end
        // Equal-age request in RECOVER is wrong-path.
        u_if0.ex0_mispred_valid = 1; u_if0.ex0_rob_idx = 6; u_if0.ex0_mispred_pc = 32'h666;
        step(); clear_inputs();
        total++; if (w_p0 !== 4'b0000 || u_if0.if_stall !== 1'b1) begin bad++;
            $display("FAIL late_equal_drop got p=%b stall=%b exp p=0000 stall=1", w_p0, u_if0.if_stall); end
        step();
        total++; if (u_if0.if_stall !== 1'b1) begin bad++; $display("FAIL late_reload got stall=%b exp=1", u_if0.if_stall); end
        u_if0.ex0_mispred_valid = 1; u_if0.ex0_rob_idx = 12; u_if0.ex0_mispred_pc = 32'hC00;
        step(); clear_inputs();
        total++; if (w_p0 !== 4'b0000 || u_if0.if_redirect_pc !== 32'h600 || u_if0.if_stall !== 1'b0) begin bad++;
            $display("FAIL late_younger_drop got p=%b pc=%h stall=%b exp p=0000 pc=600 stall=0", w_p0, u_if0.if_redirect_pc, u_if0.if_stall); end
        idle(3);
    endtask

    task automatic test_commit_priority();
        u_if0.rob_head = 0;
        u_if0.commit_redir_valid = 1; u_if0.commit_redir_pc = 32'h8000_0000;
        u_if0.ex0_mispred_valid = 1; u_if0.ex0_rob_idx = 2; u_if0.ex0_mispred_pc = 32'h200;
        step(); clear_inputs();
        total++; if (w_p0 !== 4'b1111 || u_if0.if_redirect_pc !== 32'h8000_0000) begin bad++;
            $display("FAIL commit_pulse got p=%b pc=%h exp p=1111 pc=80000000", w_p0, u_if0.if_redirect_pc); end
        u_if0.ex0_mispred_valid = 1; u_if0.ex0_rob_idx = 0; u_if0.ex0_mispred_pc = 32'hABC;
        step();
        total++; if (w_p0 !== 4'b0000 || u_if0.if_redirect_pc !== 32'h8000_0000) begin bad++;
            $display("FAIL commit_ignore1 got p=%b pc=%h exp p=0000 pc=80000000", w_p0, u_if0.if_redirect_pc); end
        step();
        total++; if (w_p0 !== 4'b0000 || u_if0.if_stall !== 1'b1) begin bad++;
            $display("FAIL commit_ignore2 got p=%b stall=%b exp p=0000 stall=1", w_p0, u_if0.if_stall); end
        step(); clear_inputs();
        total++; if (w_p0 !== 4'b0000 || u_if0.if_stall !== 1'b0) begin bad++;
            $display("FAIL commit_idle got p=%b stall=%b exp p=0000 stall=0", w_p0, u_if0.if_stall); end
        u_if0.ex0_mispred_valid = 1; u_if0.ex0_rob_idx = 4; u_if0.ex0_mispred_pc = 32'h400;
        step(); clear_inputs();
        total++; if (w_p0 !== 4'b1110 || u_if0.if_redirect_pc !== 32'h400) begin bad++;
            $display("FAIL commit_then_ex got p=%b pc=%h exp p=1110 pc=400", w_p0, u_if0.if_redirect_pc); end
        idle(4);
    endtask

    task automatic test_ext_stall();
        u_if0.rob_head = 0; u_if0.ext_stall = 1;
        u_if0.ex1_mispred_valid = 1; u_if0.ex1_rob_idx = 2; u_if0.ex1_mispred_pc = 32'h222;
        step(); u_if0.ex1_mispred_valid = 0;
        total++; if (w_p0 !== 4'b1110 || u_if0.if_stall !== 1'b1 || u_if0.if_redirect_pc !== 32'h222) begin bad++;
            $display("FAIL ext_stall_pulse got p=%b stall=%b pc=%h exp p=1110 stall=1 pc=222", w_p0, u_if0.if_stall, u_if0.if_redirect_pc); end
        idle(4);
    endtask

    task automatic test_reset_mid_recover();
        u_if0.rob_head = 0;
        u_if0.ex0_mispred_valid = 1; u_if0.ex0_rob_idx = 7; u_if0.ex0_mispred_pc = 32'h777;
        step(); clear_inputs();
        step();
        rst = 1;
        u_if0.commit_redir_valid = 1; u_if0.commit_redir_pc = 32'h9000;
        step(); rst = 0; clear_inputs();
        total++; if (w_p0 !== 4'b0000 || u_if0.if_redirect_pc !== 32'h0 || u_if0.be_flush_rob_idx !== 5'd0 || u_if0.if_stall !== 1'b0) begin bad++;
            $display("FAIL rst_mid got p=%b pc=%h idx=%0d stall=%b exp p=0000 pc=0 idx=0 stall=0", w_p0, u_if0.if_redirect_pc, u_if0.be_flush_rob_idx, u_if0.if_stall); end
        u_if0.ext_stall = 1; #1;
        total++; if (u_if0.if_stall !== 1'b1) begin bad++; $display("FAIL rst_mid_ext got stall=%b exp=1", u_if0.if_stall); end
        u_if0.ext_stall = 0;
        step();
        total++; if (w_p0 !== 4'b0000 || u_if0.if_stall !== 1'b0) begin bad++;
            $display("FAIL rst_mid_after got p=%b stall=%b exp p=0000 stall=0", w_p0, u_if0.if_stall); end
    endtask

    task automatic test_zero_recover();
        u_if1.rob_head = 0;
        u_if1.ex0_mispred_valid = 1; u_if1.ex0_rob_idx = 3; u_if1.ex0_mispred_pc = 32'h300;
        step(); clear_inputs();
        total++; if (w_p1 !== 4'b1110 || u_if1.if_redirect_pc !== 32'h300 || u_if1.if_stall !== 1'b0) begin bad++;
            $display("FAIL zero_pulse got p=%b pc=%h stall=%b exp p=1110 pc=300 stall=0", w_p1, u_if1.if_redirect_pc, u_if1.if_stall); end
        step();
        total++; if (w_p1 !== 4'b0000 || u_if1.if_stall !== 1'b0) begin bad++;
            $display("FAIL zero_idle got p=%b stall=%b exp p=0000 stall=0", w_p1, u_if1.if_stall); end
        step();
        total++; if (u_if1.if_stall !== 1'b0) begin bad++; $display("FAIL zero_idle2 got stall=%b exp=0", u_if1.if_stall); end
    endtask

    initial begin
        test_reset();
        test_basic_mispredict();
        idle(2);
        test_dual_port_wrap();
        test_equal_age();
        test_late_older();
        test_commit_priority();
        test_ext_stall();
        test_reset_mid_recover();
        idle(2);
        test_zero_recover();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Arbitrates all front-end redirect sources and sequences the IF stage through recovery.
- Sources: commit-stage trap/exception redirect, plus two execute-port branch mispredicts.
- Picks the architecturally oldest request and issues a one-cycle flush+redirect pulse to IF and the backend, then holds IF stalled for a fixed recovery window.
- Sits between commit/execute and the IF stage's flush/redirect_valid/redirect_pc/stall inputs.

Parameters:
- INST_ADDR_WIDTH, 32, PC width (`INST_ADDR_WIDTH).
- ROB_IDX_BITS, 5, ROB index width; age arithmetic is modulo 2^ROB_IDX_BITS.
- RECOVER_CYCLES, 2, IF stall cycles after each redirect pulse; 0..15 legal.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ext_stall  in  1  downstream backpressure (decode queue full).
- rob_head  in  ROB_IDX_BITS  current ROB head index.
- commit_redir_valid  in  1  trap/exception redirect.
- commit_redir_pc  in  INST_ADDR_WIDTH  trap target.
- ex0_mispred_valid  in  1  port-0 mispredict.
- ex0_mispred_pc  in  INST_ADDR_WIDTH  corrected target.
- ex0_rob_idx  in  ROB_IDX_BITS  port-0 branch ROB index.
- ex1_mispred_valid, ex1_mispred_pc, ex1_rob_idx  in  same widths  port-1 equivalents.
- if_flush  out  1  to IF flush.
- if_redirect_valid  out  1  to IF redirect_valid.
- if_redirect_pc  out  INST_ADDR_WIDTH  to IF redirect_pc.
- if_stall  out  1  to IF stall.
- be_flush_valid  out  1  backend kill pulse.
- be_flush_all  out  1  kill whole window (commit source).
- be_flush_rob_idx  out  ROB_IDX_BITS  kill entries younger than this index.

Behaviour:
- Age: age(x) = (x - rob_head) mod 2^ROB_IDX_BITS; a smaller age is older.
- Selection priority:
  - commit > older of ex0/ex1.
  - Equal ages: ex0 wins.
- States:
  - IDLE: no redirect in progress.
  - ISSUE: the one cycle in which the pulse is asserted.
  - RECOVER: counter counting RECOVER_CYCLES down to 0.
- Held context: held_idx and held_all are registers, loaded on every accepted request.
- Acceptance:
  - IDLE: any valid request is accepted.
  - ISSUE/RECOVER: commit is always accepted.
  - ISSUE/RECOVER, ex request: accepted only if held_all==0 and age(ex_idx) < age(held_idx), evaluated against the current rob_head. Younger or equal ex requests are dropped silently (wrong-path).
- Latency:
  - Request accepted in cycle N -> state ISSUE in N+1.
  - In N+1, if_flush, if_redirect_valid and be_flush_valid are all 1, all registered.
  - if_redirect_pc and be_flush_rob_idx carry the winner's values; be_flush_all=1 iff the winner is commit.
  - All three pulses are exactly one cycle unless a new request is accepted in ISSUE; that re-enters ISSUE with the new payload.
- Transitions:
  - ISSUE -> RECOVER with counter=RECOVER_CYCLES, or -> IDLE if RECOVER_CYCLES==0.
  - RECOVER: decrement counter; -> IDLE when it reaches 1.
  - Any accepted request -> ISSUE next cycle, counter reloaded.
- if_stall: combinational, = ext_stall | (state==RECOVER).
  - Deasserted during ISSUE unless ext_stall; IF flush dominates stall anyway.
- held_all is cleared on entry to IDLE.
- if_redirect_pc and be_flush_rob_idx hold their last value when not pulsing.
- Reset (rst=1 at a clock edge):
  - state IDLE; counter, held_idx, held_all = 0.
  - if_flush, if_redirect_valid, be_flush_valid, be_flush_all = 0.
  - if_redirect_pc, be_flush_rob_idx = 0.
  - Reset mid-ISSUE/RECOVER aborts; no pulse follows.
  - Requests present during the reset cycle are discarded.
- Simultaneous events:
  - commit + ex same cycle: commit wins; ex dropped.
  - ex0 + ex1 same cycle: the older one is issued and the other dropped. It is necessarily younger, so already killed.
  - ext_stall never blocks acceptance or the pulse.

Optional Feature:
- Macro: FETCH_REDIRECT_STATS_EN.
- Defined:
  - Adds outputs stat_commit_cnt, stat_ex_cnt, stat_drop_cnt, each 32 bits.
  - These count accepted commit redirects, accepted ex redirects, and dropped ex requests.
  - Counters are saturating, reset to 0 by rst, and register-updated one cycle after the event.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Basic mispredict: rob_head=0, ex0 valid idx=3 pc=0x100 at N.
  - N+1: if_flush=if_redirect_valid=be_flush_valid=1, pc=0x100, be_flush_rob_idx=3, be_flush_all=0.
  - N+2..N+3: if_stall=1.
  - N+4: IDLE, if_stall=0.
- Dual-port age with wrap: rob_head=30, ex0 idx=1 (age 3), ex1 idx=31 (age 1), same cycle.
  - Redirect pc=ex1 pc, be_flush_rob_idx=31.
- Late older request: during RECOVER after idx=10 (head=0), ex1 idx=6 -> new pulse with counter reloaded. A later ex0 idx=12 -> dropped, no pulse.
- Commit priority: commit (pc=0x8000_0000) with ex0 in the same cycle -> pulse with be_flush_all=1, pc=0x8000_0000. ex requests during the following RECOVER are ignored.
- Reset mid-RECOVER: assert rst for one cycle in RECOVER -> next cycle IDLE, all pulses 0, if_stall=ext_stall.
- RECOVER_CYCLES=0 build: one request -> pulse in one cycle, IDLE next, if_stall never asserted by the block.
